mux2x1_interleave: RTL and testbench

- Recombines the two lanes produced by the 2-lane alternating splitter into one byte stream in the original order.
- The splitter sends the first word after reset to lane 1, then lane 0, then alternates.
- Each lane has a small FIFO to absorb skew between lanes.
- An output arbiter pops strictly in lane order 1,0,1,0,… and stalls when the lane whose turn it is has no data, so order is never broken.

---
 rtl/mux2x1_interleave_pkg.sv | 17 +
 rtl/mux2x1_interleave_if.sv | 28 ++
 rtl/mux2x1_interleave_lane_fifo.sv | 71 +++++++
 rtl/mux2x1_interleave.sv | 76 +++++++
 tb/tb_mux2x1_interleave.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mux2x1_interleave_pkg.sv
// Shared definitions for the 2-lane alternating splitter and its recombiner.
// Both ends import FIRST_LANE so they agree on which lane carries word 0.
package mux_demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int NUM_LANES  = 2;

  localparam logic LANE0      = 1'b0;
  localparam logic LANE1      = 1'b1;
  localparam logic FIRST_LANE = LANE1;

  function automatic logic next_lane(input logic lane);
    return (lane == LANE1) ? LANE0 : LANE1;
  endfunction

endpackage

// File: rtl/mux2x1_interleave_if.sv
// Lane inputs and recombined-stream outputs of the interleave recombiner.
// The master drives the two lanes; the slave is the recombiner itself.
interface mux2x1_interleave_if
  import mux_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] dataIn0;
  logic              validIn0;
  logic [DATA_W-1:0] dataIn1;
  logic              validIn1;
  logic [DATA_W-1:0] dataOut;
  logic              validOut;
  logic              ovf0;
  logic              ovf1;

  modport master (
    output dataIn0, validIn0, dataIn1, validIn1,
    input  dataOut, validOut, ovf0, ovf1
  );

  modport slave (
    input  dataIn0, validIn0, dataIn1, validIn1,
    output dataOut, validOut, ovf0, ovf1
  );

endinterface

// File: rtl/mux2x1_interleave_lane_fifo.sv
// Per-lane skew FIFO: head is visible combinationally so the arbiter can
// pop and register it on the same edge. Reports dropped pushes on drop_o.
module lane_fifo
  import mux_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              full;
  logic              do_pop;
  logic              do_push;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the same edge frees a slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mux2x1_interleave.sv
// Recombines two alternating lanes into one stream, popping strictly 1,0,1,0
// and stalling when the lane whose turn it is has nothing buffered.
module mux2x1_interleave
  import mux_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  mux2x1_interleave_if.slave    bus
);

  logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0]             lane_valid;
  logic [NUM_LANES-1:0][DATA_W-1:0] head;
  logic [NUM_LANES-1:0]             empty;
  logic [NUM_LANES-1:0]             drop;
  logic [NUM_LANES-1:0]             pop;
  logic                             avail;

  logic                             turn_q;
  logic [DATA_W-1:0]                data_q;
  logic                             valid_q;
  logic [NUM_LANES-1:0]             ovf_q;

  assign lane_data[0]  = bus.dataIn0;
  assign lane_data[1]  = bus.dataIn1;
  assign lane_valid[0] = bus.validIn0;
  assign lane_valid[1] = bus.validIn1;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      // Only the lane whose turn it is may pop; the other waits even if full.
      assign pop[gi] = (turn_q == 1'(gi)) && !empty[gi];

      lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (lane_valid[gi]),
        .data_i  (lane_data[gi]),
        .pop_i   (pop[gi]),
        .head_o  (head[gi]),
        .empty_o (empty[gi]),
        .drop_o  (drop[gi])
      );
    end
  endgenerate

  assign avail = |pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      turn_q  <= FIRST_LANE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      valid_q <= avail;
      if (avail) begin
        data_q <= head[turn_q];
        turn_q <= next_lane(turn_q);
      end
      ovf_q <= ovf_q | drop;
    end
  end

  assign bus.dataOut  = data_q;
  assign bus.validOut = valid_q;
  assign bus.ovf0     = ovf_q[0];
  assign bus.ovf1     = ovf_q[1];

endmodule

// File: tb/tb_mux2x1_interleave.sv
// Directed and random stimulus for the interleave recombiner, checked against
// a queue-based reference of the lane-ordered recombination rules.
module tb_mux2x1_interleave;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  mux2x1_interleave_if #(.DATA_W(DW)) bus ();

  mux2x1_interleave #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: one queue per lane, whose turn it is, and expected outputs.
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  bit            m_turn;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf0;
  logic          m_ovf1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_turn  = 1'b1;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf0  = 1'b0;
    m_ovf1  = 1'b0;
  endtask

  task automatic model_edge(input bit v0, input logic [DW-1:0] d0,
                            input bit v1, input logic [DW-1:0] d1);
    m_valid = 1'b0;
    if (m_turn && q1.size() > 0) begin
      m_data  = q1.pop_front();
      m_valid = 1'b1;
      m_turn  = 1'b0;
    end else if (!m_turn && q0.size() > 0) begin
      m_data  = q0.pop_front();
      m_valid = 1'b1;
      m_turn  = 1'b1;
    end
    if (v0) begin
      if (q0.size() < DEPTH) q0.push_back(d0);
      else m_ovf0 = 1'b1;
    end
    if (v1) begin
      if (q1.size() < DEPTH) q1.push_back(d1);
      else m_ovf1 = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".validOut"}, 32'(bus.validOut), 32'(m_valid));
    check({tag, ".dataOut"},  32'(bus.dataOut),  32'(m_data));
    check({tag, ".ovf0"},     32'(bus.ovf0),     32'(m_ovf0));
    check({tag, ".ovf1"},     32'(bus.ovf1),     32'(m_ovf1));
  endtask

  task automatic step(input string tag, input bit v0, input logic [DW-1:0] d0,
                      input bit v1, input logic [DW-1:0] d1);
    bus.validIn0 = v0;
    bus.dataIn0  = d0;
    bus.validIn1 = v1;
    bus.dataIn1  = d1;
    @(posedge clk);
    model_edge(v0, d0, v1, d1);
    #1;
    $display("%t %s in0=%b/%02h in1=%b/%02h -> out=%b/%02h ovf=%b%b", $time, tag,
             v0, d0, v1, d1, bus.validOut, bus.dataOut, bus.ovf1, bus.ovf0);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, '0);
  endtask

  // Asserts reset between edges, checks outputs clear before any edge, then releases.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_outputs(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.validIn0 = 1'b0;
    bus.dataIn0  = '0;
    bus.validIn1 = 1'b0;
    bus.dataIn1  = '0;
    model_clear();
    #2;
    check_outputs("reset_initial");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: basic lane1 then lane0 recombination
    step("t1", 1'b0, 8'h00, 1'b1, 8'hA1);
    step("t1", 1'b1, 8'hB0, 1'b0, 8'h00);
    check("t1.first_word", 32'(bus.dataOut), 32'hA1);
    step("t1", 1'b0, 8'h00, 1'b0, 8'h00);
    check("t1.second_word", 32'(bus.dataOut), 32'hB0);
    idle("t1", 2);

    // 2: lane0 arrives early and must wait for lane1
    do_reset("t2_reset");
    step("t2", 1'b1, 8'h11, 1'b0, 8'h00);
    step("t2", 1'b1, 8'h22, 1'b0, 8'h00);
    idle("t2", 2);
    step("t2", 1'b0, 8'h00, 1'b1, 8'h33);
    idle("t2", 4);

    // 3: lane0 overflow, the dropped word never appears
    do_reset("t3_reset");
    for (int i = 1; i <= 5; i++) step("t3", 1'b1, 8'(i), 1'b0, 8'h00);
    check("t3.ovf0_set", 32'(bus.ovf0), 32'h1);
    for (int i = 0; i < 4; i++) step("t3", 1'b0, 8'h00, 1'b1, 8'(8'h90 + i));
    idle("t3", 6);

    // 4: push into a full FIFO on the edge that pops it
    do_reset("t4_reset");
    for (int i = 0; i < 4; i++) step("t4", 1'b1, 8'(8'h60 + i), 1'b0, 8'h00);
    step("t4", 1'b0, 8'h00, 1'b1, 8'h50);
    step("t4", 1'b0, 8'h00, 1'b0, 8'h00);
    step("t4", 1'b1, 8'h77, 1'b0, 8'h00);
    check("t4.no_ovf", 32'(bus.ovf0), 32'h0);
    for (int i = 0; i < 4; i++) step("t4", 1'b0, 8'h00, 1'b1, 8'(8'h51 + i));
    idle("t4", 6);

    // 5: splitter-like stream, one word per cycle alternating lanes from lane 1
    do_reset("t5_reset");
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step("t5", 1'b0, 8'h00, 1'b1, 8'(i));
      else            step("t5", 1'b1, 8'(i), 1'b0, 8'h00);
    end

    // 6: asynchronous reset mid-stream while data is buffered
    step("t6", 1'b1, 8'h41, 1'b1, 8'h40);
    step("t6", 1'b1, 8'h43, 1'b1, 8'h42);
    check("t6.streaming", 32'(bus.validOut), 32'h1);
    do_reset("t6_async_reset");
    step("t6", 1'b1, 8'hC0, 1'b0, 8'h00);
    step("t6", 1'b1, 8'hC2, 1'b0, 8'h00);
    step("t6", 1'b0, 8'h00, 1'b1, 8'hD1);
    idle("t6", 4);

    // Random lane activity, including skew and overflow
    do_reset("rand_reset");
    for (int i = 0; i < 300; i++) begin
      automatic bit            v0 = ($urandom_range(0, 99) < 55);
      automatic bit            v1 = ($urandom_range(0, 99) < 55);
      automatic logic [DW-1:0] d0 = 8'($urandom);
      automatic logic [DW-1:0] d1 = 8'($urandom);
      step("rand", v0, d0, v1, d1);
    end
    idle("rand_drain", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
